// File: rtl/word_serializer_mod7_pkg.sv
// Shared types and constants for the word serializer feeding the serial mod-7 checker.
package word_serializer_mod7_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int REM_W = 4;
endpackage

// File: rtl/word_serializer_mod7_if.sv
// Word handshake, checker link and result handshake bundled for the serializer.
interface word_serializer_mod7_if #(parameter int WIDTH = 8);
  import word_serializer_mod7_pkg::*;

  logic [WIDTH-1:0] Word_In;
  logic             Word_Valid;
  logic             Word_Ready;
  logic             STRING_Out;
  logic             Clear_Out;
  logic [REM_W-1:0] Remainder_In;
  logic             Divisible_In;
  logic             Result_Valid;
  logic [REM_W-1:0] Result_Remainder;
  logic             Result_Divisible;
  logic             Result_Ack;

  // master = producer/checker/consumer side, slave = the serializer
  modport master (
    output Word_In, Word_Valid, Remainder_In, Divisible_In, Result_Ack,
    input  Word_Ready, STRING_Out, Clear_Out, Result_Valid, Result_Remainder, Result_Divisible
  );

  modport slave (
    input  Word_In, Word_Valid, Remainder_In, Divisible_In, Result_Ack,
    output Word_Ready, STRING_Out, Clear_Out, Result_Valid, Result_Remainder, Result_Divisible
  );
endinterface

// File: rtl/word_serializer_mod7.sv
// Loads a parallel word, shifts it MSB-first into the mod-7 checker, then holds
// the checker's verdict until the consumer acknowledges it.
module word_serializer_mod7
  import word_serializer_mod7_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic                  Clock,
  input logic                  Reset,
  word_serializer_mod7_if.slave bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [REM_W-1:0] res_rem;
  logic             res_div;
  logic             ready, clear, valid;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Word_Valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    if (bus.Result_Ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    clear = 1'b0;
    valid = 1'b0;
    case (state)
      IDLE:    begin ready = 1'b1; clear = 1'b1; end
      DONE:    begin clear = 1'b1; valid = 1'b1; end
      default: ;
    endcase
  end

  // Zero-fill guarantees shreg is all-zero outside SHIFT, so its MSB is the
  // registered serial output with no state gating.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      shreg   <= '0;
      cnt     <= '0;
      res_rem <= '0;
      res_div <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.Word_Valid) begin
          shreg <= bus.Word_In;
          cnt   <= CNT_W'(WIDTH);
        end
        SHIFT: begin
          shreg <= shreg << 1;
          cnt   <= cnt - CNT_W'(1);
        end
        WAIT: begin
          res_rem <= bus.Remainder_In;
          res_div <= bus.Divisible_In;
        end
        default: ;
      endcase
    end
  end

  assign bus.Word_Ready       = ready;
  assign bus.Clear_Out        = clear;
  assign bus.Result_Valid     = valid;
  assign bus.STRING_Out       = shreg[WIDTH-1];
  assign bus.Result_Remainder = res_rem;
  assign bus.Result_Divisible = res_div;

endmodule

// File: tb/tb_word_serializer_mod7.sv
// Directed bench: serializer driving a behavioural serial mod-7 checker.
module tb_word_serializer_mod7;
  import word_serializer_mod7_pkg::*;

  localparam int WIDTH = 8;

  logic Clock = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  word_serializer_mod7_if #(.WIDTH(WIDTH)) bus ();

  word_serializer_mod7 #(.WIDTH(WIDTH)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  // Serial checker: remainder of the bit string seen so far, cleared while Clear is high.
  logic [REM_W-1:0] chk_rem;
  logic [4:0]       chk_acc;
  always_comb chk_acc = {chk_rem, 1'b0} + {4'd0, bus.STRING_Out};
  always_ff @(posedge Clock) begin
    if (Reset || bus.Clear_Out) chk_rem <= '0;
    else                        chk_rem <= 4'(chk_acc % 5'd7);
  end
  assign bus.Remainder_In = chk_rem;
  assign bus.Divisible_In = (chk_rem == '0);

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake on the next edge, then follow the word bit by bit to the result.
  task automatic send_word(input logic [7:0] w, input logic [3:0] rem, input logic dv);
    bus.Word_In    = w;
    bus.Word_Valid = 1'b1;
    step();
    bus.Word_Valid = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      chk($sformatf("string_bit%0d", k), 32'(bus.STRING_Out), 32'(w[WIDTH-1-k]));
      chk("clear_shift", 32'(bus.Clear_Out), 0);
      chk("ready_shift", 32'(bus.Word_Ready), 0);
      step();
    end
    chk("valid_wait", 32'(bus.Result_Valid), 0);
    chk("string_wait", 32'(bus.STRING_Out), 0);
    step();
    chk("valid_done", 32'(bus.Result_Valid), 1);
    chk("rem_done", 32'(bus.Result_Remainder), 32'(rem));
    chk("div_done", 32'(bus.Result_Divisible), 32'(dv));
    chk("clear_done", 32'(bus.Clear_Out), 1);
  endtask

  task automatic ack();
    bus.Result_Ack = 1'b1;
    step();
    bus.Result_Ack = 1'b0;
    chk("valid_after_ack", 32'(bus.Result_Valid), 0);
    chk("ready_after_ack", 32'(bus.Word_Ready), 1);
  endtask

  initial begin
    Reset          = 1'b1;
    bus.Word_In    = '0;
    bus.Word_Valid = 1'b0;
    bus.Result_Ack = 1'b0;
    step();
    step();
    Reset = 1'b0;
    chk("rst_ready", 32'(bus.Word_Ready), 1);
    chk("rst_clear", 32'(bus.Clear_Out), 1);
    chk("rst_valid", 32'(bus.Result_Valid), 0);
    chk("rst_string", 32'(bus.STRING_Out), 0);
    chk("rst_rem", 32'(bus.Result_Remainder), 0);

    send_word(8'h55, 4'd1, 1'b0);
    ack();

    send_word(8'h0E, 4'd0, 1'b1);
    // Result held while unacknowledged; a new word offered now must be ignored.
    bus.Word_In    = 8'hFF;
    bus.Word_Valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(bus.Result_Valid), 1);
      chk("hold_rem", 32'(bus.Result_Remainder), 0);
      chk("hold_div", 32'(bus.Result_Divisible), 1);
      chk("hold_ready", 32'(bus.Word_Ready), 0);
    end
    ack();
    send_word(8'hFF, 4'd3, 1'b0);
    ack();
    chk("rem_kept_after_ack", 32'(bus.Result_Remainder), 3);

    // Reset during the 4th SHIFT cycle drops the word.
    bus.Word_In    = 8'h55;
    bus.Word_Valid = 1'b1;
    step();
    bus.Word_Valid = 1'b0;
    step();
    step();
    step();
    chk("mid_shift_clear", 32'(bus.Clear_Out), 0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midrst_ready", 32'(bus.Word_Ready), 1);
    chk("midrst_clear", 32'(bus.Clear_Out), 1);
    chk("midrst_valid", 32'(bus.Result_Valid), 0);
    chk("midrst_string", 32'(bus.STRING_Out), 0);
    send_word(8'h07, 4'd0, 1'b1);
    ack();

    // Reset wins over Word_Valid on the same edge.
    bus.Word_In    = 8'h55;
    bus.Word_Valid = 1'b1;
    Reset          = 1'b1;
    step();
    Reset          = 1'b0;
    bus.Word_Valid = 1'b0;
    chk("rstvld_ready", 32'(bus.Word_Ready), 1);
    chk("rstvld_clear", 32'(bus.Clear_Out), 1);
    chk("rstvld_string", 32'(bus.STRING_Out), 0);
    step();
    chk("rstvld_still_idle", 32'(bus.Word_Ready), 1);
    chk("rstvld_string2", 32'(bus.STRING_Out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
